// File: rtl/game2048_pkg.sv
// Shared types for the 2048 game input path.
// Move FSM states, move directions and the press priority helper.
package game2048_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ISSUE        = 2'd1,
        WAIT_RELEASE = 2'd2
    } move_fsm_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } move_dir_t;

    // lv bit order: {right, left, down, up}; up wins over everything
    function automatic move_dir_t pick_dir(input logic [3:0] lv);
        if (lv[0])
            return UP;
        else if (lv[1])
            return DOWN;
        else if (lv[2])
            return LEFT;
        return RIGHT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer; MOVE_INPUT_SYNC_EN adds a two-flop
// synchronizer ahead of the debounce counter.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    logic             sample;
    logic [CNT_W-1:0] cnt;

`ifdef MOVE_INPUT_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync <= '0;
        else
            sync <= {sync[0], btn};
    end

    assign sample = sync[1];
`else
    assign sample = btn;
`endif

    // Any sample agreeing with the stable level restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sample == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sample;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/move_input_ctrl.sv
// Pushbutton to one-shot move pulse controller for game2048.
// Optional MOVE_INPUT_SYNC_EN enables input synchronizers.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic key_active
);

    import game2048_pkg::*;

    logic [3:0] btn_raw;
    logic [3:0] level;
    move_fsm_t  state;
    move_dir_t  dir;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[i]),
            .level(level[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dir   <= UP;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|level) begin
                        state <= ISSUE;
                        dir   <= pick_dir(level);
                    end
                end
                ISSUE:
                    state <= WAIT_RELEASE;
                WAIT_RELEASE: begin
                    if (~|level)
                        state <= IDLE;
                end
                default:
                    state <= IDLE;
            endcase
        end
    end

    // Outputs are flops so nothing reaches them combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            key_active <= 1'b0;
        end else begin
            move_up    <= (state == ISSUE) && (dir == UP);
            move_down  <= (state == ISSUE) && (dir == DOWN);
            move_left  <= (state == ISSUE) && (dir == LEFT);
            move_right <= (state == ISSUE) && (dir == RIGHT);
            key_active <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Randomised and directed bench for move_input_ctrl.
// Build with DEBOUNCE_CYCLES=4 and MOVE_INPUT_SYNC_EN undefined.
module tb_move_input_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic move_up, move_down, move_left, move_right, key_active;

    int errors = 0;
    int checks = 0;

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .move_up   (move_up),
        .move_down (move_down),
        .move_left (move_left),
        .move_right(move_right),
        .key_active(key_active)
    );

    always #5 clk = ~clk;

    // Behavioural model: a level is accepted once the last D samples
    // all disagree with it; the controller is a 3-phase machine whose
    // outputs appear one cycle after the phase that causes them.
    bit       m_stable [4];
    bit       m_hist   [4][$];
    int       m_phase;
    int       m_dir;
    bit [3:0] m_smp;
    bit [3:0] exp_move;
    bit       exp_key;
    bit       m_any;
    bit       m_all_diff;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  = 0;
            m_dir    = 0;
            exp_move = '0;
            exp_key  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_stable[i] = 1'b0;
                m_hist[i].delete();
            end
        end else begin
            m_smp    = {btn_right, btn_left, btn_down, btn_up};
            exp_move = (m_phase == 1) ? 4'(1 << m_dir) : 4'd0;
            exp_key  = (m_phase != 0);
            m_any    = 1'b0;
            for (int i = 0; i < 4; i++)
                if (m_stable[i]) m_any = 1'b1;
            if (m_phase == 0) begin
                if (m_any) begin
                    m_phase = 1;
                    for (int i = 3; i >= 0; i--)
                        if (m_stable[i]) m_dir = i;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (!m_any) begin
                m_phase = 0;
            end
            for (int i = 0; i < 4; i++) begin
                m_hist[i].push_back(m_smp[i]);
                if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
                m_all_diff = (m_hist[i].size() == D);
                foreach (m_hist[i][j])
                    if (m_hist[i][j] == m_stable[i]) m_all_diff = 1'b0;
                if (m_all_diff) begin
                    m_stable[i] = m_smp[i];
                    m_hist[i].delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({move_right, move_left, move_down, move_up, key_active}
            !== {exp_move, exp_key}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got move=%b key=%b want move=%b key=%b",
                     $time, {move_right, move_left, move_down, move_up},
                     key_active, exp_move, exp_key);
        end
    end

    int w_first [4];
    int w_cnt   [4];
    int w_key_hi;
    int w_key_lo;

    // Samples outputs #1 after each of the next n edges; k=0 is the
    // edge that first sees inputs driven at the preceding negedge.
    task automatic watch(input int n);
        bit [3:0] mv;
        for (int i = 0; i < 4; i++) begin
            w_first[i] = -1;
            w_cnt[i]   = 0;
        end
        w_key_hi = -1;
        w_key_lo = -1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            mv = {move_right, move_left, move_down, move_up};
            for (int i = 0; i < 4; i++) begin
                if (mv[i]) begin
                    w_cnt[i]++;
                    if (w_first[i] < 0) w_first[i] = k;
                end
            end
            if (key_active && w_key_hi < 0) w_key_hi = k;
            if (!key_active && w_key_lo < 0) w_key_lo = k;
        end
        @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    int acc_up;
    int acc_left;
    bit found;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({move_up, move_down, move_left, move_right, key_active}), 0);
        reset = 1'b0;
        @(negedge clk);

        // clean press and release
        btn_up = 1'b1;
        watch(10);
        check("clean_up_cycle", w_first[0], 5);
        check("clean_up_count", w_cnt[0], 1);
        check("clean_key_rise", w_key_hi, 5);
        btn_up = 1'b0;
        watch(10);
        check("clean_key_fall", w_key_lo, 5);

        // bounce on left
        for (int i = 0; i < 5; i++) begin
            btn_left = (i % 2 == 0);
            @(negedge clk);
        end
        btn_left = 1'b0;
        watch(12);
        check("bounce_moves", w_cnt[0] + w_cnt[1] + w_cnt[2] + w_cnt[3], 0);
        check("bounce_key", w_key_hi, -1);

        // simultaneous down and right
        btn_down  = 1'b1;
        btn_right = 1'b1;
        watch(12);
        check("simul_down", w_cnt[1], 1);
        check("simul_others", w_cnt[0] + w_cnt[2] + w_cnt[3], 0);
        btn_down  = 1'b0;
        btn_right = 1'b0;
        watch(12);

        // hold up, add left mid-hold
        btn_up = 1'b1;
        watch(10);
        acc_up   = w_cnt[0];
        acc_left = w_cnt[2];
        btn_left = 1'b1;
        watch(10);
        acc_up   += w_cnt[0];
        acc_left += w_cnt[2];
        btn_up = 1'b0;
        watch(5);
        acc_up   += w_cnt[0];
        acc_left += w_cnt[2];
        btn_left = 1'b0;
        watch(10);
        acc_up   += w_cnt[0];
        acc_left += w_cnt[2];
        check("hold_up_once", acc_up, 1);
        check("hold_no_left", acc_left, 0);
        btn_left = 1'b1;
        watch(10);
        check("repress_left_cycle", w_first[2], 5);
        btn_left = 1'b0;
        watch(12);

        // reset during the ISSUE pulse
        btn_up = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (move_up) found = 1'b1;
        end
        check("reset_wait_pulse", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        check("reset_cuts_pulse", int'({move_up, key_active}), 0);
        @(negedge clk);
        reset = 1'b0;
        watch(10);
        check("post_reset_cycle", w_first[0], 5);
        btn_up = 1'b0;
        watch(12);

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            {btn_right, btn_left, btn_down, btn_up} = 4'($urandom);
            if ($urandom_range(0, 2) == 0)
                {btn_right, btn_left, btn_down, btn_up} = '0;
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end
        {btn_right, btn_left, btn_down, btn_up} = '0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
